// File: rtl/apb_master_if.sv
// Bundle of signals between apb_master, its command client and the APB
// responders.
//   command side : cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata
//   response side: rsp_valid/rsp_rdata/rsp_err/rsp_timeout
//   APB side     : psel/penable/pwrite/paddr/pwdata, prdata/pready/pslverr
// modport master is the apb_master view. modport slave is the view of the
// surrounding logic, which is the client plus the responders.
interface apb_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// APB initiator. It turns one command handshake into one SETUP/ACCESS
// transfer and reports completion with a one-cycle rsp_valid pulse.
//   pclk    : bus clock. All logic is on the rising edge.
//   presetn : asynchronous, active-low reset.
//   bus     : apb_master_if.master. It carries the command and response
//             handshake and the APB bus.
// Parameters:
//   ADDR_W, DATA_W : widths of the APB address and data.
//   TIMEOUT        : most ACCESS cycles without pready before the transfer is
//                    forced to end with rsp_err=1 and rsp_timeout=1.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  apb_master_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  wait_cnt;
  logic              accept, done_ok, done_to;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, rdata_n;
  logic              write_n;

  assign bus.cmd_ready = (state == IDLE);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_n;
  end

  // paddr/pwrite/pwdata are loaded only on a handshake. Between transfers
  // they keep the values of the last transfer.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    addr_n  = bus.paddr;
    wdata_n = bus.pwdata;
    write_n = bus.pwrite;
    rdata_n = '0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          addr_n  = bus.cmd_addr;
          wdata_n = bus.cmd_wdata;
          write_n = bus.cmd_write;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          done_ok = 1'b1;
          if (!bus.pwrite) rdata_n = bus.prdata;
          state_n = IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          done_to = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= '0;
      bus.pwdata      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      wait_cnt        <= '0;
    end else begin
      bus.paddr     <= addr_n;
      bus.pwdata    <= wdata_n;
      bus.pwrite    <= write_n;
      bus.rsp_valid <= done_ok | done_to;
      if (accept) begin
        bus.psel    <= 1'b1;
        bus.penable <= 1'b0;
      end
      // The counter cannot wrap. ACCESS ends no later than the cycle in
      // which it reaches TIMEOUT-1.
      if (state == SETUP) begin
        bus.penable <= 1'b1;
        wait_cnt    <= '0;
      end else if (state == ACCESS && !(done_ok || done_to)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (done_ok || done_to) begin
        bus.psel        <= 1'b0;
        bus.penable     <= 1'b0;
        bus.rsp_rdata   <= rdata_n;
        bus.rsp_err     <= done_to | (done_ok & bus.pslverr);
        bus.rsp_timeout <= done_to;
      end
    end
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that turns single-beat command requests from on-chip logic into APB SETUP/ACCESS transfers and returns completion status. It sits between a local control client (register sequencer, debug bridge) and one or more APB responders on the 8-bit address / 8-bit data peripheral bus. It supports responder wait states, PSLVERR reporting and a programmable wait-state timeout.

## Interface
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data width
- TIMEOUT, 16, max ACCESS cycles without PREADY before forced termination (≥2)
- pclk  in  1  bus clock; all logic on rising edge
- presetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  client requests a transfer
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data (ignored on reads)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR seen or timeout, qualified by rsp_valid
- rsp_timeout  out  1  termination was by timeout, qualified by rsp_valid
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  ADDR_W;  pwdata  out  DATA_W  APB address/data
- prdata  in  DATA_W;  pready  in  1;  pslverr  in  1  APB responder returns

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state IDLE.
- cmd_ready = 1 exactly when state is IDLE (combinational from state); no command queueing.
- IDLE: on cmd_valid && cmd_ready, latch cmd_write/addr/wdata into pwrite/paddr/pwdata, set psel=1, penable=0, go to SETUP.
- SETUP: always one cycle; set penable=1, clear wait counter, go to ACCESS.
- ACCESS: hold psel, penable, paddr, pwrite, pwdata stable.
  - pready=1 sampled: psel=0, penable=0, rsp_valid=1, rsp_err=pslverr, rsp_timeout=0, rsp_rdata=prdata if read else 0; go to IDLE.
  - pready=0 and wait counter = TIMEOUT-1: terminate same as above but rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - else: increment wait counter (width $clog2(TIMEOUT), never wraps).
- pslverr and prdata are sampled only in the ACCESS cycle where pready=1; ignored otherwise.
- paddr/pwrite/pwdata keep last transfer's values in IDLE (no toggling); pwdata updated on reads too (from cmd_wdata).
- rsp_valid is a single-cycle pulse with no backpressure; rsp_rdata/rsp_err/rsp_timeout hold until next completion.

## Timing
- Reset values: psel 0, penable 0, pwrite 0, paddr 0, pwdata 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, rsp_timeout 0, cmd_ready 1 after reset release.
- Handshake at edge E0 → psel high E0..; penable high from E1; earliest completion edge E2 (pready in first ACCESS cycle) → rsp_valid high E2..E3, cmd_ready high from E2.
- Each wait state adds one cycle. Minimum command-to-command spacing: 3 cycles (new handshake possible in the rsp_valid cycle).
- Timeout: pready low for TIMEOUT ACCESS cycles → completion at edge E1+TIMEOUT.
- presetn asserted mid-transfer: all outputs to reset values immediately (asynchronous), no rsp_valid, FSM to IDLE; pending command dropped.
- cmd_valid in non-IDLE states has no effect; client must hold cmd_* until cmd_ready.

## Test plan
- Write 0x3C to 0x10, pready tied 1 in ACCESS → psel E0, penable E1, completion E2; rsp_valid one cycle, rsp_err 0, pwdata 0x3C, pwrite 1 throughout.
- Read 0x10 from a 256-byte APB responder model that asserts pready one cycle late → one wait state, rsp_rdata 0x3C, rsp_valid at E3, paddr stable E0–E3.
- Read with pslverr=1 alongside pready → rsp_err 1, rsp_timeout 0, rsp_rdata = prdata sampled; pslverr pulses without pready ignored.
- TIMEOUT=4, pready held 0 → exactly 4 ACCESS cycles, then rsp_valid, rsp_err 1, rsp_timeout 1, rsp_rdata 0, psel/penable dropped.
- Back-to-back: cmd_valid held high with 3 commands, zero-wait responder → accepts every 3 cycles, responses in order, no psel gap beyond one IDLE cycle.
- presetn pulsed low during ACCESS with wait states → psel/penable 0 immediately, no rsp_valid, cmd_ready 1 after release, next command completes normally.
